lab62soc_pio_in_irq: RTL and testbench

LAB62SOC_PIO_IN_IRQ -- requirements
Module: lab62soc_pio_in_irq

---
 rtl/lab62soc_pio_pkg.sv | 25 ++
 rtl/lab62soc_pio_debounce.sv | 58 +++++
 rtl/lab62soc_pio_in_irq.sv | 94 +++++++++
 tb/tb_lab62soc_pio_in_irq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab62soc_pio_pkg.sv
// Shared definitions for the input PIO with edge-capture interrupt:
// register word addresses, edge capture modes and the per-bit edge test.
package lab62soc_pio_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   typedef enum logic [1:0] {
      RISING  = 2'd0,
      FALLING = 2'd1,
      ANY     = 2'd2
   } edge_type_e;

   // True when the transition prev -> cur matches the selected capture mode.
   function automatic logic edge_hit(input edge_type_e mode, input logic cur, input logic prev);
      case (mode)
         RISING:  return cur & ~prev;
         FALLING: return ~cur & prev;
         default: return cur ^ prev;
      endcase
   endfunction

endpackage

// File: rtl/lab62soc_pio_debounce.sv
// One input bit: two-flop synchronizer followed by an optional stable-count
// debouncer. With DEBOUNCE_CYCLES=0 the synchronized bit is used directly.
module lab62soc_pio_debounce #(
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic dout
);

   logic meta_reg;
   logic sync_reg;

   // Bring the asynchronous pin into the clk domain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= din;
         sync_reg <= meta_reg;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign dout = sync_reg;
      end else begin : g_debounce
         localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

         logic [CNT_W-1:0] cnt_reg;
         logic             deb_reg;

         // Accept a new level only after it has differed for DEBOUNCE_CYCLES
         // consecutive cycles; any return to the accepted level restarts.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_reg <= '0;
               deb_reg <= 1'b0;
            end else if (sync_reg != deb_reg) begin
               if (cnt_reg == CNT_LAST) begin
                  deb_reg <= sync_reg;
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end else begin
               cnt_reg <= '0;
            end
         end

         assign dout = deb_reg;
      end
   endgenerate

endmodule

// File: rtl/lab62soc_pio_in_irq.sv
// Avalon-MM input PIO: synchronized/debounced inputs, edge capture with
// write-1-to-clear, interrupt mask and a registered level interrupt.
module lab62soc_pio_in_irq
   import lab62soc_pio_pkg::*;
#(
   parameter int         WIDTH           = 2,
   parameter int         DEBOUNCE_CYCLES = 0,
   parameter edge_type_e EDGE_TYPE       = RISING
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] deb_value;
   logic [WIDTH-1:0] prev_reg;
   logic [WIDTH-1:0] edge_hit_vec;
   logic [WIDTH-1:0] mask_reg;
   logic [WIDTH-1:0] edge_reg;
   logic [WIDTH-1:0] edge_next;
   logic [31:0]      readdata_reg;
   logic [31:0]      readdata_next;
   logic             irq_reg;
   logic             wr_en;
   logic             writedata_unused;

   // Upper write bits are deliberately don't-care.
   assign writedata_unused = ^writedata;
   assign wr_en            = chipselect & ~write_n;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         lab62soc_pio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[gi]),
            .dout    (deb_value[gi])
         );
         assign edge_hit_vec[gi] = edge_hit(EDGE_TYPE, deb_value[gi], prev_reg[gi]);
      end
   endgenerate

   // Clear requested bits first, then OR in new edges so a same-cycle edge survives.
   always_comb begin
      edge_next = edge_reg;
      if (wr_en && (address == ADDR_EDGE)) begin
         edge_next = edge_reg & ~writedata[WIDTH-1:0];
      end
      edge_next = edge_next | edge_hit_vec;
   end

   // Read mux; result is registered every cycle for one-cycle latency.
   always_comb begin
      readdata_next = '0;
      case (address)
         ADDR_DATA: readdata_next = 32'(deb_value);
         ADDR_RSVD: readdata_next = '0;
         ADDR_MASK: readdata_next = 32'(mask_reg);
         default:   readdata_next = 32'(edge_reg);
      endcase
   end

   // Register state: previous level, mask, captured edges, read data, interrupt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_reg     <= '0;
         mask_reg     <= '0;
         edge_reg     <= '0;
         readdata_reg <= '0;
         irq_reg      <= 1'b0;
      end else begin
         prev_reg     <= deb_value;
         edge_reg     <= edge_next;
         readdata_reg <= readdata_next;
         irq_reg      <= |(edge_reg & mask_reg);
         if (wr_en && (address == ADDR_MASK)) begin
            mask_reg <= writedata[WIDTH-1:0];
         end
      end
   end

   assign readdata = readdata_reg;
   assign irq      = irq_reg;

endmodule

// File: tb/tb_lab62soc_pio_in_irq.sv
// Directed bench: DUT A (WIDTH=2, DEBOUNCE_CYCLES=4, RISING) and
// DUT B (WIDTH=2, DEBOUNCE_CYCLES=0, ANY). Inputs change and outputs are
// observed on the falling clock edge.
module tb_lab62soc_pio_in_irq;
   import lab62soc_pio_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [1:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   logic [1:0]  address_b;
   logic        chipselect_b;
   logic        write_n_b;
   logic [31:0] writedata_b;
   logic [1:0]  in_port_b;
   logic [31:0] readdata_b;
   logic        irq_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lab62soc_pio_in_irq #(
      .WIDTH(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(RISING)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   lab62soc_pio_in_irq #(
      .WIDTH(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(ANY)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .address(address_b), .chipselect(chipselect_b),
      .write_n(write_n_b), .writedata(writedata_b), .in_port(in_port_b),
      .readdata(readdata_b), .irq(irq_b)
   );

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic bus_write_b(input logic [1:0] a, input logic [31:0] d);
      address_b    = a;
      writedata_b  = d;
      chipselect_b = 1'b1;
      write_n_b    = 1'b0;
      @(negedge clk);
      chipselect_b = 1'b0;
      write_n_b    = 1'b1;
      writedata_b  = '0;
   endtask

   task automatic apply_reset();
      reset_n      = 1'b0;
      in_port      = '0;
      in_port_b    = '0;
      chipselect   = 1'b0;
      write_n      = 1'b1;
      writedata    = '0;
      address      = ADDR_DATA;
      chipselect_b = 1'b0;
      write_n_b    = 1'b1;
      writedata_b  = '0;
      address_b    = ADDR_DATA;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      in_port = 2'b11;
      reset_n = 1'b0;
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         @(negedge clk);
         total++;
         if (readdata !== 32'h0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_regs addr=%0d got rd=%h irq=%b want rd=0 irq=0", a, readdata, irq);
         end else $display("ok reset_regs addr=%0d", a);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_rise();
      apply_reset();
      address = ADDR_DATA;
      in_port = 2'b01;
      repeat (6) @(negedge clk);
      total++;
      if (readdata !== 32'h0) begin
         bad++; $display("FAIL data_early got=%h want=%h", readdata, 32'h0);
      end else $display("ok data_early");
      @(negedge clk);
      total++;
      if (readdata !== 32'h1) begin
         bad++; $display("FAIL data_ready got=%h want=%h", readdata, 32'h1);
      end else $display("ok data_ready");
      address = ADDR_EDGE;
      @(negedge clk);
      total++;
      if (readdata !== 32'h1 || irq !== 1'b0) begin
         bad++; $display("FAIL rise_edge got rd=%h irq=%b want rd=1 irq=0", readdata, irq);
      end else $display("ok rise_edge");
   endtask

   task automatic test_glitch();
      apply_reset();
      address = ADDR_DATA;
      in_port = 2'b01;
      repeat (3) @(negedge clk);
      in_port = 2'b00;
      repeat (12) @(negedge clk);
      total++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         bad++; $display("FAIL glitch_data got rd=%h irq=%b want rd=0 irq=0", readdata, irq);
      end else $display("ok glitch_data");
      address = ADDR_EDGE;
      @(negedge clk);
      total++;
      if (readdata !== 32'h0) begin
         bad++; $display("FAIL glitch_edge got=%h want=%h", readdata, 32'h0);
      end else $display("ok glitch_edge");
   endtask

   task automatic test_irq();
      apply_reset();
      bus_write(ADDR_MASK, 32'hFFFF_FFF2);
      @(negedge clk);
      total++;
      if (readdata !== 32'h2) begin
         bad++; $display("FAIL mask_readback got=%h want=%h", readdata, 32'h2);
      end else $display("ok mask_readback");
      address = ADDR_RSVD;
      @(negedge clk);
      total++;
      if (readdata !== 32'h0) begin
         bad++; $display("FAIL reserved_read got=%h want=%h", readdata, 32'h0);
      end else $display("ok reserved_read");
      bus_write(ADDR_DATA, 32'h3);
      @(negedge clk);
      total++;
      if (readdata !== 32'h0) begin
         bad++; $display("FAIL data_ro got=%h want=%h", readdata, 32'h0);
      end else $display("ok data_ro");
      address = ADDR_EDGE;
      in_port = 2'b10;
      repeat (7) @(negedge clk);
      total++;
      if (irq !== 1'b0 || readdata !== 32'h0) begin
         bad++; $display("FAIL irq_before got irq=%b rd=%h want irq=0 rd=0", irq, readdata);
      end else $display("ok irq_before");
      @(negedge clk);
      total++;
      if (irq !== 1'b1 || readdata !== 32'h2) begin
         bad++; $display("FAIL irq_assert got irq=%b rd=%h want irq=1 rd=2", irq, readdata);
      end else $display("ok irq_assert");
      bus_write(ADDR_EDGE, 32'h2);
      total++;
      if (irq !== 1'b1) begin
         bad++; $display("FAIL irq_hold got=%b want=1", irq);
      end else $display("ok irq_hold");
      @(negedge clk);
      total++;
      if (irq !== 1'b0 || readdata !== 32'h0) begin
         bad++; $display("FAIL irq_clear got irq=%b rd=%h want irq=0 rd=0", irq, readdata);
      end else $display("ok irq_clear");
      in_port = 2'b11;
      repeat (10) @(negedge clk);
      total++;
      if (irq !== 1'b0 || readdata !== 32'h1) begin
         bad++; $display("FAIL irq_masked got irq=%b rd=%h want irq=0 rd=1", irq, readdata);
      end else $display("ok irq_masked");
   endtask

   task automatic test_set_wins();
      apply_reset();
      address = ADDR_EDGE;
      in_port = 2'b01;
      repeat (6) @(negedge clk);
      bus_write(ADDR_EDGE, 32'h1);
      @(negedge clk);
      total++;
      if (readdata !== 32'h1) begin
         bad++; $display("FAIL set_wins got=%h want=%h", readdata, 32'h1);
      end else $display("ok set_wins");
      bus_write(ADDR_EDGE, 32'h1);
      @(negedge clk);
      total++;
      if (readdata !== 32'h0) begin
         bad++; $display("FAIL w1c got=%h want=%h", readdata, 32'h0);
      end else $display("ok w1c");
   endtask

   task automatic test_reset_mid();
      apply_reset();
      bus_write(ADDR_MASK, 32'h1);
      address = ADDR_EDGE;
      in_port = 2'b01;
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      #1;
      total++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         bad++; $display("FAIL mid_reset_regs got rd=%h irq=%b want rd=0 irq=0", readdata, irq);
      end else $display("ok mid_reset_regs");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (7) @(negedge clk);
      total++;
      if (readdata !== 32'h0) begin
         bad++; $display("FAIL mid_no_early got=%h want=%h", readdata, 32'h0);
      end else $display("ok mid_no_early");
      @(negedge clk);
      total++;
      if (readdata !== 32'h1 || irq !== 1'b0) begin
         bad++; $display("FAIL mid_edge got rd=%h irq=%b want rd=1 irq=0", readdata, irq);
      end else $display("ok mid_edge");
      address = ADDR_MASK;
      @(negedge clk);
      total++;
      if (readdata !== 32'h0) begin
         bad++; $display("FAIL mid_mask got=%h want=%h", readdata, 32'h0);
      end else $display("ok mid_mask");
   endtask

   task automatic test_any();
      apply_reset();
      address_b = ADDR_EDGE;
      in_port_b = 2'b01;
      repeat (3) @(negedge clk);
      total++;
      if (readdata_b !== 32'h0) begin
         bad++; $display("FAIL any_early got=%h want=%h", readdata_b, 32'h0);
      end else $display("ok any_early");
      @(negedge clk);
      total++;
      if (readdata_b !== 32'h1) begin
         bad++; $display("FAIL any_rise got=%h want=%h", readdata_b, 32'h1);
      end else $display("ok any_rise");
      bus_write_b(ADDR_EDGE, 32'h1);
      @(negedge clk);
      total++;
      if (readdata_b !== 32'h0) begin
         bad++; $display("FAIL any_clear1 got=%h want=%h", readdata_b, 32'h0);
      end else $display("ok any_clear1");
      in_port_b = 2'b00;
      repeat (4) @(negedge clk);
      total++;
      if (readdata_b !== 32'h1 || irq_b !== 1'b0) begin
         bad++; $display("FAIL any_fall got rd=%h irq=%b want rd=1 irq=0", readdata_b, irq_b);
      end else $display("ok any_fall");
      bus_write_b(ADDR_EDGE, 32'h1);
      @(negedge clk);
      total++;
      if (readdata_b !== 32'h0) begin
         bad++; $display("FAIL any_clear2 got=%h want=%h", readdata_b, 32'h0);
      end else $display("ok any_clear2");
   endtask

   initial begin
      reset_n = 1'b0;
      test_reset();
      test_rise();
      test_glitch();
      test_irq();
      test_set_wins();
      test_reset_mid();
      test_any();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
